rv32i_multicycle: RTL and testbench

- Parametrised multi-cycle RV32I-subset core; successor to the fixed single-instruction datapath top.
- Fetches instructions over a request/ready memory port, executes a decoded subset, and accesses data memory over a second request/ready port.
- Reports retirement and halts on illegal or misaligned operations.
- Sits at the top of the pico SoC, between instruction ROM and data RAM.

---
 rtl/rv32i_multicycle.sv | 195 +++++++++++++++++++
 tb/tb_rv32i_multicycle.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC [-> MEM] -> FETCH, with a sticky HALT state.
// Instruction and data ports use a simple request/ready handshake.
module rv32i_multicycle #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned NREGS     = 32,
   parameter bit          BRANCH_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        retire,
   output logic        halted
);
   localparam int unsigned IW = $clog2(NREGS);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_MEM   = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_JAL    = 7'h6f;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;

   logic [1:0]  state;
   logic [31:0] pc, ir;
   logic [31:0] rf [NREGS];

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic [31:0] rs1_val, rs2_val, op_b, alu_res, pc_plus4, mem_addr;
   logic [31:0] wb_val, next_pc;
   logic        legal, wb_en, is_mem, taken;

   function automatic logic reg_ok(input logic [4:0] idx);
      return 32'(idx) < NREGS;
   endfunction

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign imm_u = {ir[31:12], 12'h000};

   // Out-of-range indices alias into the file here but are rejected as illegal below.
   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1[IW-1:0]];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2[IW-1:0]];
   assign op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
   assign pc_plus4 = pc + 32'd4;
   assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
   assign taken    = (rs1_val == rs2_val) ^ funct3[0];

   always_comb begin
      alu_res = 32'd0;
      unique case (funct3)
         3'b000: alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - op_b : rs1_val + op_b;
         3'b001: alu_res = rs1_val << op_b[4:0];
         3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
         3'b011: alu_res = {31'd0, rs1_val < op_b};
         3'b100: alu_res = rs1_val ^ op_b;
         3'b101: alu_res = funct7[5] ? 32'($signed(rs1_val) >>> op_b[4:0])
                                     : rs1_val >> op_b[4:0];
         3'b110: alu_res = rs1_val | op_b;
         3'b111: alu_res = rs1_val & op_b;
      endcase
   end

   always_comb begin
      legal   = 1'b0;
      wb_en   = 1'b0;
      wb_val  = alu_res;
      next_pc = pc_plus4;
      is_mem  = 1'b0;
      case (opcode)
         OPC_OPIMM: begin
            wb_en = 1'b1;
            legal = reg_ok(rd) && reg_ok(rs1);
            if (funct3 == 3'b001 && funct7 != 7'h00) legal = 1'b0;
            if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) legal = 1'b0;
         end
         OPC_OP: begin
            wb_en = 1'b1;
            legal = reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2) &&
                    (funct7 == 7'h00 ||
                     (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OPC_LUI: begin
            wb_en  = 1'b1;
            wb_val = imm_u;
            legal  = reg_ok(rd);
         end
         OPC_JAL: begin
            wb_en   = 1'b1;
            wb_val  = pc_plus4;
            next_pc = pc + imm_j;
            legal   = reg_ok(rd);
         end
         OPC_BRANCH: begin
            legal = BRANCH_EN && funct3[2:1] == 2'b00 && reg_ok(rs1) && reg_ok(rs2);
            if (taken) next_pc = pc + imm_b;
         end
         OPC_LOAD: begin
            is_mem = 1'b1;
            legal  = funct3 == 3'b010 && reg_ok(rd) && reg_ok(rs1) && mem_addr[1:0] == 2'b00;
         end
         OPC_STORE: begin
            is_mem = 1'b1;
            legal  = funct3 == 3'b010 && reg_ok(rs1) && reg_ok(rs2) && mem_addr[1:0] == 2'b00;
         end
         default: ;
      endcase
      if (!is_mem && next_pc[1:0] != 2'b00) legal = 1'b0;
   end

   assign imem_addr = pc;
   assign halted    = (state == ST_HALT);
   assign retire    = !reset && ((state == ST_EXEC && legal && !is_mem) ||
                                 (state == ST_MEM && dmem_ready));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_FETCH;
         pc         <= RESET_PC;
         ir         <= 32'd0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
         for (int unsigned i = 0; i < NREGS; i++) rf[i] <= 32'd0;
      end else begin
         case (state)
            ST_FETCH: begin
               // Only the first cycle after reset arrives here with the request still low.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ready) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!legal) begin
                  state <= ST_HALT;
               end else if (is_mem) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= (opcode == OPC_STORE);
                  dmem_addr  <= mem_addr;
                  dmem_wdata <= rs2_val;
                  state      <= ST_MEM;
               end else begin
                  if (wb_en && rd != 5'd0) rf[rd[IW-1:0]] <= wb_val;
                  pc       <= next_pc;
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            ST_MEM: begin
               if (dmem_ready) begin
                  if (!dmem_we && rd != 5'd0) rf[rd[IW-1:0]] <= dmem_rdata;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  pc       <= pc_plus4;
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rv32i_multicycle.sv
// Directed bench for rv32i_multicycle: small programs with hand-computed results,
// plus a second instance configured as RV32E (16 registers).
module tb_rv32i_multicycle;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic        i16_req, d16_req, d16_we, r16, h16;
   logic [31:0] i16_addr, i16_rdata, d16_addr, d16_wdata;

   logic [31:0] imem [128];
   logic [31:0] dmem [64];
   logic        ready_en = 1'b1;
   logic [31:0] stall_addr = 32'hFFFF_FFFF;
   int          dly = 0;
   int          wait_cnt = 0, ret_cnt = 0, dreq_cnt = 0;
   logic [31:0] fetch_q [$];
   int          n_chk = 0, n_pass = 0;

   localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, LUI = 7'h37, LDO = 7'h03;

   always #5 clk = ~clk;

   rv32i_multicycle dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .retire(retire), .halted(halted)
   );

   rv32i_multicycle #(.NREGS(16)) dut16 (
      .clk(clk), .reset(reset),
      .imem_req(i16_req), .imem_addr(i16_addr), .imem_ready(ready_en),
      .imem_rdata(i16_rdata),
      .dmem_req(d16_req), .dmem_we(d16_we), .dmem_addr(d16_addr),
      .dmem_wdata(d16_wdata), .dmem_ready(1'b1), .dmem_rdata(32'd0),
      .retire(r16), .halted(h16)
   );

   assign imem_ready = ready_en && (imem_addr != stall_addr);
   assign imem_rdata = imem[imem_addr[8:2]];
   assign i16_rdata  = imem[i16_addr[8:2]];
   assign dmem_ready = dmem_req && (wait_cnt >= dly);
   assign dmem_rdata = dmem[dmem_addr[7:2]];

   // Memory model and event counters; counters restart with every reset.
   always @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 0;
         ret_cnt  <= 0;
         dreq_cnt <= 0;
         fetch_q.delete();
         for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
         dmem[3] <= 32'h5A5A_1234;
      end else begin
         wait_cnt <= (dmem_req && !dmem_ready) ? wait_cnt + 1 : 0;
         if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
         if (retire) ret_cnt <= ret_cnt + 1;
         if (dmem_req) dreq_cnt <= dreq_cnt + 1;
         if (imem_req && imem_ready) fetch_q.push_back(imem_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPR};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 128; i++) imem[i] = 32'd0;
   endtask

   task automatic start();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_retires(input string tag, input int n, input int budget);
      int t = 0;
      while (ret_cnt < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(tag, ret_cnt, n);
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int t = 0;
      while (!halted && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(halted), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, t;
      logic bad;

      // ADDI x1,x0,42 with a cycle-exact view of the first instruction.
      clear_imem();
      imem[0] = 32'h02A0_0093;
      start();
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      chk("c1_imem_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      chk("c2_retire", 32'(retire), 32'd1);
      @(negedge clk);
      chk("c3_imem_addr", imem_addr, 32'd4);
      chk("c3_retire", 32'(retire), 32'd0);
      chk("addi_x1", dut.rf[1], 32'd42);

      // ALU coverage with wrap-around and signed/unsigned distinctions.
      clear_imem();
      imem[0]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPI);      // ADDI x1,x0,-1
      imem[1]  = enc_i(12'h01C, 5'd1, 3'd5, 5'd2, OPI);      // SRLI x2,x1,28
      imem[2]  = enc_i(12'h404, 5'd1, 3'd5, 5'd3, OPI);      // SRAI x3,x1,4
      imem[3]  = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd4);       // ADD  x4,x1,x1
      imem[4]  = enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd8);       // SUB  x8,x0,x1
      imem[5]  = enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd9);       // SLTU x9,x0,x1
      imem[6]  = enc_i(12'h000, 5'd1, 3'd2, 5'd6, OPI);      // SLTI x6,x1,0
      imem[7]  = enc_r(7'h00, 5'd1, 5'd0, 3'd2, 5'd7);       // SLT  x7,x0,x1
      imem[8]  = enc_i(12'h0F0, 5'd1, 3'd7, 5'd10, OPI);     // ANDI x10,x1,0xF0
      imem[9]  = {20'h12345, 5'd12, LUI};                    // LUI  x12,0x12345
      imem[10] = enc_i(12'h678, 5'd12, 3'd6, 5'd15, OPI);    // ORI  x15,x12,0x678
      imem[11] = enc_r(7'h00, 5'd2, 5'd2, 3'd1, 5'd13);      // SLL  x13,x2,x2
      imem[12] = enc_r(7'h00, 5'd12, 5'd15, 3'd4, 5'd14);    // XOR  x14,x15,x12
      imem[13] = enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd11);      // SRA  x11,x1,x2
      start();
      run_retires("alu_retires", 14, 200);
      chk("srli", dut.rf[2], 32'h0000_000F);
      chk("srai", dut.rf[3], 32'hFFFF_FFFF);
      chk("add_wrap", dut.rf[4], 32'hFFFF_FFFE);
      chk("sub", dut.rf[8], 32'd1);
      chk("sltu", dut.rf[9], 32'd1);
      chk("slti", dut.rf[6], 32'd1);
      chk("slt", dut.rf[7], 32'd0);
      chk("andi", dut.rf[10], 32'h0000_00F0);
      chk("lui", dut.rf[12], 32'h1234_5000);
      chk("ori", dut.rf[15], 32'h1234_5678);
      chk("sll", dut.rf[13], 32'h0007_8000);
      chk("xor", dut.rf[14], 32'h0000_0678);
      chk("sra", dut.rf[11], 32'hFFFF_FFFF);

      // Store then loads with three wait cycles on the data port.
      clear_imem();
      imem[0] = {20'hABCDE, 5'd1, LUI};                      // LUI  x1,0xABCDE
      imem[1] = enc_i(12'h123, 5'd1, 3'd0, 5'd1, OPI);       // ADDI x1,x1,0x123
      imem[2] = enc_s(12'd8, 5'd1, 5'd0);                    // SW   x1,8(x0)
      imem[3] = enc_i(12'd8, 5'd0, 3'd2, 5'd5, LDO);         // LW   x5,8(x0)
      imem[4] = enc_i(12'd12, 5'd0, 3'd2, 5'd6, LDO);        // LW   x6,12(x0)
      dly = 3;
      start();
      t = 0;
      while (!dmem_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("sw_req", 32'(dmem_req), 32'd1);
      n = 0;
      bad = 1'b0;
      while (dmem_req && n < 20) begin
         n++;
         if (dmem_addr !== 32'd8 || dmem_we !== 1'b1 || dmem_wdata !== 32'hABCD_E123) bad = 1'b1;
         if (dmem_ready) break;
         @(negedge clk);
      end
      chk("sw_held_stable", 32'(bad), 32'd0);
      chk("sw_req_cycles", n, 32'd4);
      run_retires("mem_retires", 5, 200);
      wait_halt("mem_halt", 50);
      chk("mem_retire_once", ret_cnt, 32'd5);
      chk("sw_data", dmem[2], 32'hABCD_E123);
      chk("lw_x5", dut.rf[5], 32'hABCD_E123);
      chk("lw_x6", dut.rf[6], 32'h5A5A_1234);
      dly = 0;

      // Branches and jumps; also confirms data-port registers return to reset values.
      clear_imem();
      imem[0] = enc_j(21'h10, 5'd0);                         // JAL x0,+0x10
      imem[4] = enc_b(13'h8, 5'd0, 5'd0, 3'd0);              // 0x10 BEQ x0,x0,+8
      imem[6] = enc_b(13'h8, 5'd0, 5'd0, 3'd1);              // 0x18 BNE x0,x0,+8
      imem[7] = enc_j(21'h4, 5'd0);                          // 0x1C JAL x0,+4
      imem[8] = enc_j(21'h100, 5'd1);                        // 0x20 JAL x1,+0x100
      start();
      @(negedge clk);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      chk("rst_dmem_we", 32'(dmem_we), 32'd0);
      wait_halt("br_halt", 100);
      chk("br_fetch_count", fetch_q.size(), 32'd6);
      if (fetch_q.size() == 6) begin
         chk("br_fetch0", fetch_q[0], 32'h00);
         chk("br_fetch1", fetch_q[1], 32'h10);
         chk("beq_taken", fetch_q[2], 32'h18);
         chk("bne_not_taken", fetch_q[3], 32'h1C);
         chk("jal_from", fetch_q[4], 32'h20);
         chk("jal_target", fetch_q[5], 32'h120);
      end
      chk("jal_link", dut.rf[1], 32'h24);
      chk("br_retires", ret_cnt, 32'd5);

      // Halting cases: illegal opcode, misaligned load, misaligned jump target.
      clear_imem();
      start();
      repeat (8) @(negedge clk);
      chk("ill_halted", 32'(halted), 32'd1);
      chk("ill_retire", ret_cnt, 32'd0);
      chk("ill_no_req", 32'(imem_req), 32'd0);
      chk("ill_pc", imem_addr, 32'd0);
      chk("ill_fetches", fetch_q.size(), 32'd1);
      imem[0] = enc_i(12'd6, 5'd0, 3'd2, 5'd5, LDO);         // LW x5,6(x0)
      start();
      repeat (8) @(negedge clk);
      chk("mis_lw_halted", 32'(halted), 32'd1);
      chk("mis_lw_retire", ret_cnt, 32'd0);
      chk("mis_lw_no_dreq", dreq_cnt, 32'd0);
      imem[0] = enc_j(21'h2, 5'd1);                          // JAL x1,+2
      start();
      repeat (8) @(negedge clk);
      chk("mis_pc_halted", 32'(halted), 32'd1);
      chk("mis_pc_retire", ret_cnt, 32'd0);
      chk("mis_pc_no_link", dut.rf[1], 32'd0);
      start();
      @(negedge clk);
      chk("unhalt", 32'(halted), 32'd0);
      chk("unhalt_pc", imem_addr, 32'd0);

      // Reset while a fetch is stalled mid-request.
      clear_imem();
      imem[0] = enc_j(21'h40, 5'd0);
      stall_addr = 32'h40;
      start();
      t = 0;
      while (imem_addr != 32'h40 && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, 32'h40);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midreq_rst_req", 32'(imem_req), 32'd0);
      chk("midreq_rst_pc", imem_addr, 32'd0);
      @(negedge clk);
      chk("midreq_refetch", 32'(imem_req), 32'd1);
      stall_addr = 32'hFFFF_FFFF;

      // x0 writes ignored; x20 legal for RV32I, illegal for the 16-register instance.
      clear_imem();
      imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI);         // ADDI x0,x0,5
      imem[1] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, OPI);         // ADDI x1,x0,7
      imem[2] = enc_r(7'h00, 5'd1, 5'd0, 3'd0, 5'd2);        // ADD  x2,x0,x1
      imem[3] = enc_i(12'd9, 5'd0, 3'd0, 5'd3, OPI);         // ADDI x3,x0,9
      imem[4] = enc_i(12'd1, 5'd0, 3'd0, 5'd20, OPI);        // ADDI x20,x0,1
      imem[5] = enc_j(21'h0, 5'd0);                          // JAL  x0,0
      start();
      run_retires("x0_retires", 6, 100);
      chk("x0_reads_zero", dut.rf[2], 32'd7);
      chk("x20_rv32i", dut.rf[20], 32'd1);
      chk("rv32i_running", 32'(halted), 32'd0);
      chk("rv32e_halted", 32'(h16), 32'd1);
      chk("rv32e_x3", dut16.rf[3], 32'd9);
      chk("rv32e_pc", i16_addr, 32'h10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
